// File: rtl/core_bpred.sv
// core_bpred: 2-bit PHT branch predictor with execute-stage resolve/redirect; CORE_BPRED_STATS_EN adds branch/mispredict counters
module core_bpred #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            d_valid,
    input  logic            d_is_branch,
    input  logic [XLEN-1:0] d_pc,
    input  logic [XLEN-1:0] d_imm,
    input  logic            x_valid,
    input  logic            x_is_branch,
    input  logic            x_is_jump,
    input  logic            x_predicted_taken,
    input  logic [2:0]      x_branch_cond,
    input  logic [XLEN-1:0] x_rs1,
    input  logic [XLEN-1:0] x_rs2,
    input  logic [XLEN-1:0] x_pc,
    input  logic [XLEN-1:0] x_pc_new,
    output logic            d_flush,
    output logic            d_predicted_taken,
    output logic            pc_load,
    output logic [XLEN-1:0] pc_new,
    output logic            init_busy
`ifdef CORE_BPRED_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);
    localparam int IW = $clog2(ENTRIES);

    typedef enum logic {INIT, READY} state_t;

    state_t        state;
    logic [IW-1:0] sweep_idx;
    logic [1:0]    pht [ENTRIES];
    logic [IW-1:0] d_idx;
    logic [IW-1:0] x_idx;
    logic [1:0]    x_ctr;
    logic          eq;
    logic          lt;
    logic          ltu;
    logic          cond;
    logic          fire;
    logic          x_res;
    logic          mis_taken;
    logic          mis_not;
    logic          x_redir;
    logic          d_pred;
    logic          d_take;

    // Resolve the execute branch, then let an execute redirect override any decode prediction
    always_comb begin
        d_idx             = d_pc[IW+1:2];
        x_idx             = x_pc[IW+1:2];
        x_ctr             = pht[x_idx];
        eq                = x_rs1 == x_rs2;
        lt                = $signed(x_rs1) < $signed(x_rs2);
        ltu               = x_rs1 < x_rs2;
        cond              = x_branch_cond[2:1] == 2'b00 ? eq ^ x_branch_cond[0] :
                            x_branch_cond[2:1] == 2'b10 ? lt ^ x_branch_cond[0] :
                            x_branch_cond[2:1] == 2'b11 ? ltu ^ x_branch_cond[0] : 1'b0;
        fire              = x_is_jump | (x_is_branch & cond);
        x_res             = x_valid & (x_is_branch | x_is_jump);
        mis_taken         = x_res & fire & ~x_predicted_taken;
        mis_not           = x_res & ~fire & x_predicted_taken;
        x_redir           = mis_taken | mis_not;
        d_pred            = state == READY ? pht[d_idx][1] : d_imm[XLEN-1];
        d_take            = ~x_redir & d_valid & d_is_branch & d_pred;
        d_flush           = x_redir;
        d_predicted_taken = d_take;
        pc_load           = x_redir | d_take;
        pc_new            = mis_taken ? x_pc_new :
                            mis_not   ? x_pc + XLEN'(4) :
                            d_take    ? d_pc + d_imm : '0;
        init_busy         = state == INIT;
    end

    // Sweep every entry to weakly-not-taken after reset; training is ignored until the sweep completes
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            sweep_idx <= '0;
        end else if (state == INIT) begin
            pht[sweep_idx] <= 2'b01;
            sweep_idx      <= sweep_idx + 1'b1;
            state          <= sweep_idx == IW'(ENTRIES - 1) ? READY : INIT;
        end else if (x_valid & x_is_branch) begin
            pht[x_idx] <= fire ? (x_ctr == 2'b11 ? x_ctr : x_ctr + 2'b01)
                               : (x_ctr == 2'b00 ? x_ctr : x_ctr - 2'b01);
        end
    end

`ifdef CORE_BPRED_STATS_EN
    // Count resolved control transfers and execute redirects, wrapping naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            stat_branches    <= stat_branches + 32'(x_res);
            stat_mispredicts <= stat_mispredicts + 32'(x_redir);
        end
    end
`endif
endmodule

// File: tb/tb_core_bpred.sv
// tb_core_bpred: directed and randomized checks of core_bpred against a behavioural predictor model
module tb_core_bpred;
    localparam int XLEN    = 32;
    localparam int ENTRIES = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            d_valid;
    logic            d_is_branch;
    logic [XLEN-1:0] d_pc;
    logic [XLEN-1:0] d_imm;
    logic            x_valid;
    logic            x_is_branch;
    logic            x_is_jump;
    logic            x_predicted_taken;
    logic [2:0]      x_branch_cond;
    logic [XLEN-1:0] x_rs1;
    logic [XLEN-1:0] x_rs2;
    logic [XLEN-1:0] x_pc;
    logic [XLEN-1:0] x_pc_new;
    logic            d_flush;
    logic            d_predicted_taken;
    logic            pc_load;
    logic [XLEN-1:0] pc_new;
    logic            init_busy;
`ifdef CORE_BPRED_STATS_EN
    logic [31:0]     stat_branches;
    logic [31:0]     stat_mispredicts;
`endif

    int checks   = 0;
    int failures = 0;

    int          m_pht [ENTRIES];
    bit          m_ready;
    int          m_sweep;
    logic [31:0] m_br;
    logic [31:0] m_mis;

    always #5 clk = ~clk;

    core_bpred #(.XLEN(XLEN), .ENTRIES(ENTRIES)) dut (
        .clk(clk),
        .rst(rst),
        .d_valid(d_valid),
        .d_is_branch(d_is_branch),
        .d_pc(d_pc),
        .d_imm(d_imm),
        .x_valid(x_valid),
        .x_is_branch(x_is_branch),
        .x_is_jump(x_is_jump),
        .x_predicted_taken(x_predicted_taken),
        .x_branch_cond(x_branch_cond),
        .x_rs1(x_rs1),
        .x_rs2(x_rs2),
        .x_pc(x_pc),
        .x_pc_new(x_pc_new),
        .d_flush(d_flush),
        .d_predicted_taken(d_predicted_taken),
        .pc_load(pc_load),
        .pc_new(pc_new),
        .init_busy(init_busy)
`ifdef CORE_BPRED_STATS_EN
        ,
        .stat_branches(stat_branches),
        .stat_mispredicts(stat_mispredicts)
`endif
    );

    function automatic bit m_cond();
        case (x_branch_cond)
            3'd0:    return x_rs1 == x_rs2;
            3'd1:    return x_rs1 != x_rs2;
            3'd4:    return $signed(x_rs1) < $signed(x_rs2);
            3'd5:    return $signed(x_rs1) >= $signed(x_rs2);
            3'd6:    return x_rs1 < x_rs2;
            3'd7:    return x_rs1 >= x_rs2;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_fire();
        return x_is_jump || (x_is_branch && m_cond());
    endfunction

    function automatic void m_eval(output bit f, output bit l, output bit p, output logic [31:0] a);
        bit fire;
        bit xres;
        fire = m_fire();
        xres = x_valid && (x_is_branch || x_is_jump);
        f = 0;
        l = 0;
        p = 0;
        a = 0;
        if (xres && fire != x_predicted_taken) begin
            f = 1;
            l = 1;
            a = fire ? x_pc_new : x_pc + 32'd4;
        end else if (d_valid && d_is_branch &&
                     (m_ready ? m_pht[(d_pc >> 2) % ENTRIES] >= 2 : d_imm[31])) begin
            l = 1;
            p = 1;
            a = d_pc + d_imm;
        end
    endfunction

    task automatic cycle();
        bit f;
        bit fl;
        bit lo;
        bit pt;
        logic [31:0] a;
        int idx;
        f = m_fire();
        m_eval(fl, lo, pt, a);
        @(posedge clk);
        if (rst) begin
            m_ready = 0;
            m_sweep = 0;
            m_br    = 0;
            m_mis   = 0;
        end else begin
            if (!m_ready) begin
                m_pht[m_sweep] = 1;
                m_sweep++;
                if (m_sweep == ENTRIES) m_ready = 1;
            end else if (x_valid && x_is_branch) begin
                idx = int'((x_pc >> 2) % ENTRIES);
                m_pht[idx] = f ? (m_pht[idx] == 3 ? 3 : m_pht[idx] + 1)
                               : (m_pht[idx] == 0 ? 0 : m_pht[idx] - 1);
            end
            if (x_valid && (x_is_branch || x_is_jump)) m_br++;
            if (fl) m_mis++;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        d_valid = 0; d_is_branch = 0; d_pc = 0; d_imm = 0;
        x_valid = 0; x_is_branch = 0; x_is_jump = 0; x_predicted_taken = 0;
        x_branch_cond = 0; x_rs1 = 0; x_rs2 = 0; x_pc = 0; x_pc_new = 0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 3));
            1:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 2));
            2:       return 32'h8000_0000 + 32'($urandom_range(0, 1));
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_inputs();
        d_valid           = 1'($urandom_range(0, 1));
        d_is_branch       = $urandom_range(0, 3) != 0;
        d_pc              = 32'($urandom_range(0, 127)) << 2;
        d_imm             = $urandom_range(0, 1) != 0 ? -(32'($urandom_range(1, 64)) << 2)
                                                      : 32'($urandom_range(1, 64)) << 2;
        x_valid           = 1'($urandom_range(0, 1));
        x_is_branch       = $urandom_range(0, 3) != 0;
        x_is_jump         = $urandom_range(0, 4) == 0;
        x_predicted_taken = 1'($urandom_range(0, 1));
        x_branch_cond     = 3'($urandom_range(0, 7));
        x_rs1             = pick();
        x_rs2             = pick();
        x_pc              = $urandom_range(0, 1) != 0 ? d_pc : 32'($urandom_range(0, 127)) << 2;
        x_pc_new          = $urandom & ~32'h3;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        #1;
        checks++;
        if ({d_flush, pc_load, d_predicted_taken} !== 3'b000 || pc_new !== 0) begin
            failures++;
            $display("FAIL reset_outputs got flush/load/pred=%b%b%b pc_new=%h exp 000/0",
                     d_flush, pc_load, d_predicted_taken, pc_new);
        end
        cycle();
        rst = 0;
        #1;
        checks++;
        if (init_busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_busy_start got=%b exp=1", init_busy);
        end
        for (int i = 0; i < ENTRIES; i++) begin
            cycle();
            #1;
            checks++;
            if (init_busy !== (i < ENTRIES - 1)) begin
                failures++;
                $display("FAIL reset_busy_count cycle=%0d got=%b exp=%b", i + 1, init_busy, i < ENTRIES - 1);
            end
        end
`ifdef CORE_BPRED_STATS_EN
        checks++;
        if (stat_branches !== 0 || stat_mispredicts !== 0) begin
            failures++;
            $display("FAIL reset_stats got=%0d/%0d exp=0/0", stat_branches, stat_mispredicts);
        end
`endif
        for (int k = 0; k < ENTRIES; k++) begin
            d_valid = 1; d_is_branch = 1; d_pc = 32'(k) << 2; d_imm = 32'hFFFF_FFF0;
            #1;
            checks++;
            if (pc_load !== 1'b0 || d_predicted_taken !== 1'b0) begin
                failures++;
                $display("FAIL init_entry idx=%0d got load/pred=%b%b exp=00", k, pc_load, d_predicted_taken);
            end
            cycle();
        end
        idle();
    endtask

    task automatic test_beq_mispredict();
        idle();
        x_valid = 1; x_is_branch = 1; x_branch_cond = 3'd0; x_rs1 = 5; x_rs2 = 5;
        x_predicted_taken = 0; x_pc = 32'h80; x_pc_new = 32'h100;
        #1;
        checks++;
        if (d_flush !== 1'b1 || pc_load !== 1'b1 || pc_new !== 32'h100 || d_predicted_taken !== 1'b0) begin
            failures++;
            $display("FAIL beq_redirect got flush/load/pred=%b%b%b pc_new=%h exp 110/100",
                     d_flush, pc_load, d_predicted_taken, pc_new);
        end
        cycle();
        idle();
        d_valid = 1; d_is_branch = 1; d_pc = 32'h80; d_imm = 32'h10;
        #1;
        checks++;
        if (pc_load !== 1'b1 || d_predicted_taken !== 1'b1 || pc_new !== 32'h90 || d_flush !== 1'b0) begin
            failures++;
            $display("FAIL beq_trained got load/pred/flush=%b%b%b pc_new=%h exp 110/90",
                     pc_load, d_predicted_taken, d_flush, pc_new);
        end
        cycle();
        idle();
    endtask

    task automatic test_signed_unsigned();
        idle();
        x_valid = 1; x_is_branch = 1; x_branch_cond = 3'd4; x_rs1 = 32'hFFFF_FFFF; x_rs2 = 1;
        x_predicted_taken = 1; x_pc = 32'h200; x_pc_new = 32'h300;
        #1;
        checks++;
        if (d_flush !== 1'b0 || pc_load !== 1'b0 || pc_new !== 0) begin
            failures++;
            $display("FAIL blt_no_redirect got flush/load=%b%b pc_new=%h exp 00/0", d_flush, pc_load, pc_new);
        end
        cycle();
        x_branch_cond = 3'd6;
        #1;
        checks++;
        if (d_flush !== 1'b1 || pc_load !== 1'b1 || pc_new !== 32'h204) begin
            failures++;
            $display("FAIL bltu_fallthrough got flush/load=%b%b pc_new=%h exp 11/204", d_flush, pc_load, pc_new);
        end
        cycle();
        idle();
    endtask

    task automatic test_saturate();
        idle();
        for (int i = 0; i < 3; i++) begin
            x_valid = 1; x_is_branch = 1; x_branch_cond = 3'd0; x_rs1 = 7; x_rs2 = 7;
            x_predicted_taken = 1; x_pc = 32'h40; x_pc_new = 32'h60;
            #1;
            checks++;
            if (pc_load !== 1'b0 || d_flush !== 1'b0) begin
                failures++;
                $display("FAIL sat_train step=%0d got load/flush=%b%b exp=00", i, pc_load, d_flush);
            end
            cycle();
        end
        idle();
        d_valid = 1; d_is_branch = 1; d_pc = 32'h40; d_imm = 32'h20;
        #1;
        checks++;
        if (pc_load !== 1'b1 || pc_new !== 32'h60 || d_predicted_taken !== 1'b1 || d_flush !== 1'b0) begin
            failures++;
            $display("FAIL sat_predict got load/pred/flush=%b%b%b pc_new=%h exp 110/60",
                     pc_load, d_predicted_taken, d_flush, pc_new);
        end
        cycle();
        idle();
    endtask

    task automatic test_priority();
        idle();
        d_valid = 1; d_is_branch = 1; d_pc = 32'h40; d_imm = 32'h20;
        x_valid = 1; x_is_jump = 1; x_predicted_taken = 0; x_pc = 32'h600; x_pc_new = 32'h500;
        #1;
        checks++;
        if (d_flush !== 1'b1 || pc_load !== 1'b1 || pc_new !== 32'h500 || d_predicted_taken !== 1'b0) begin
            failures++;
            $display("FAIL priority got flush/load/pred=%b%b%b pc_new=%h exp 110/500",
                     d_flush, pc_load, d_predicted_taken, pc_new);
        end
        cycle();
        idle();
    endtask

    task automatic test_read_before_write();
        idle();
        x_valid = 1; x_is_branch = 1; x_branch_cond = 3'd0; x_rs1 = 1; x_rs2 = 2;
        x_predicted_taken = 0; x_pc = 32'h40;
        cycle();
        d_valid = 1; d_is_branch = 1; d_pc = 32'h40; d_imm = 32'h20;
        #1;
        checks++;
        if (pc_load !== 1'b1 || d_predicted_taken !== 1'b1 || pc_new !== 32'h60) begin
            failures++;
            $display("FAIL rbw_same_cycle got load/pred=%b%b pc_new=%h exp 11/60", pc_load, d_predicted_taken, pc_new);
        end
        cycle();
        x_valid = 0;
        #1;
        checks++;
        if (pc_load !== 1'b0 || d_predicted_taken !== 1'b0 || pc_new !== 0) begin
            failures++;
            $display("FAIL rbw_after got load/pred=%b%b pc_new=%h exp 00/0", pc_load, d_predicted_taken, pc_new);
        end
        cycle();
        idle();
    endtask

    task automatic test_random(input int n);
        bit ef;
        bit el;
        bit ep;
        logic [31:0] ea;
        for (int i = 0; i < n; i++) begin
            rand_inputs();
            #1;
            m_eval(ef, el, ep, ea);
            checks++;
            if (d_flush !== ef || pc_load !== el || d_predicted_taken !== ep || pc_new !== ea) begin
                failures++;
                $display("FAIL rand_outputs i=%0d got flush/load/pred=%b%b%b pc_new=%h exp %b%b%b/%h",
                         i, d_flush, pc_load, d_predicted_taken, pc_new, ef, el, ep, ea);
            end
            checks++;
            if (init_busy !== !m_ready) begin
                failures++;
                $display("FAIL rand_busy i=%0d got=%b exp=%b", i, init_busy, !m_ready);
            end
`ifdef CORE_BPRED_STATS_EN
            checks++;
            if (stat_branches !== m_br || stat_mispredicts !== m_mis) begin
                failures++;
                $display("FAIL rand_stats i=%0d got=%0d/%0d exp=%0d/%0d", i, stat_branches, stat_mispredicts, m_br, m_mis);
            end
`endif
            cycle();
        end
        idle();
    endtask

    task automatic test_reset_midsweep();
        idle();
        rst = 1;
        cycle();
        rst = 0;
        test_random(30);
        rst = 1;
        #1;
        checks++;
        if ({d_flush, pc_load, d_predicted_taken} !== 3'b000 || pc_new !== 0) begin
            failures++;
            $display("FAIL midsweep_rst_outputs got=%b%b%b pc_new=%h exp 000/0",
                     d_flush, pc_load, d_predicted_taken, pc_new);
        end
        cycle();
        rst = 0;
        #1;
`ifdef CORE_BPRED_STATS_EN
        checks++;
        if (stat_branches !== 0 || stat_mispredicts !== 0) begin
            failures++;
            $display("FAIL midsweep_stats got=%0d/%0d exp=0/0", stat_branches, stat_mispredicts);
        end
`endif
        for (int i = 0; i < ENTRIES; i++) begin
            checks++;
            if (init_busy !== 1'b1) begin
                failures++;
                $display("FAIL midsweep_busy cycle=%0d got=%b exp=1", i, init_busy);
            end
            cycle();
            #1;
        end
        checks++;
        if (init_busy !== 1'b0) begin
            failures++;
            $display("FAIL midsweep_done got=%b exp=0", init_busy);
        end
        for (int k = 0; k < ENTRIES; k += 7) begin
            d_valid = 1; d_is_branch = 1; d_pc = 32'(k) << 2; d_imm = 32'hFFFF_FF00;
            #1;
            checks++;
            if (pc_load !== 1'b0) begin
                failures++;
                $display("FAIL midsweep_entry idx=%0d got load=%b exp=0", k, pc_load);
            end
            cycle();
        end
        idle();
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_beq_mispredict();
        test_signed_unsigned();
        test_saturate();
        test_priority();
        test_read_before_write();
        test_random(400);
        test_reset_midsweep();
        test_random(300);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
